// File: rtl/trapezoid_shaper.sv
// Trapezoidal pulse shaper: k/l delay-line difference, pole-zero correction (M),
// double accumulation and saturated output, with FILL/RUN/FLUSH sequencing.
`ifndef SIZE_ADC_DATA
`define SIZE_ADC_DATA 14
`endif
`ifndef SIZE_FILTER_DATA
`define SIZE_FILTER_DATA 16
`endif

module trapezoid_shaper #(
  parameter int ADC_W = `SIZE_ADC_DATA,
  parameter int OUT_W = `SIZE_FILTER_DATA,
  parameter int DEPTH = 32,
  parameter int M_W   = 8,
  parameter int ACC_W = 32,
  parameter int SHIFT = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADC_W-1:0]             in_data,
  input  logic                         cfg_load,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_k,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_l,
  input  logic [M_W-1:0]               cfg_m,
  output logic                         cfg_err,
  output logic                         out_valid,
  output logic signed [OUT_W-1:0]      out_data,
  output logic                         sat_flag
);

  localparam int CW     = $clog2(DEPTH+1);
  localparam int STAGES = 4;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  fill_q, fill_d;
  logic [2:0]     flush_q, flush_d;
  logic [CW-1:0]  k_q, k_d, l_q, l_d;
  logic [M_W-1:0] m_q, m_d;
  logic           cfg_err_q, cfg_err_d;
  logic           sat_q, sat_d;
  logic           acc, cfg_ok, cfg_acc, flush_done;
  logic [CW-1:0]  kl;

  logic [DEPTH:0][ADC_W-1:0] x_q, x_d;
  // [0]: sample in delay line, [1]: d, [2]: p, [3]: r, [4]: s
  logic [STAGES:0]           vld_pipe_q, vld_pipe_d;
  logic [STAGES:0]           emit_pipe_q, emit_pipe_d;
  logic signed [ACC_W-1:0]   d_q, d_d, d2_q, d2_d, p_q, p_d, r_q, r_d, s_q, s_d;
  logic signed [ACC_W-1:0]   m_ext, sh;
  logic                      clamp;
  logic                      out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]   out_data_q, out_data_d;

  function automatic logic signed [ACC_W-1:0] zext(input logic [ADC_W-1:0] v);
    return {{(ACC_W-ADC_W){1'b0}}, v};
  endfunction

  assign in_ready   = (state_q != FLUSH);
  assign acc        = in_valid && in_ready;
  assign cfg_ok     = (cfg_k != '0) && (cfg_k <= cfg_l) &&
                      (({1'b0, cfg_k} + {1'b0, cfg_l}) <= DEPTH_C);
  assign cfg_acc    = cfg_load && in_ready && cfg_ok;
  assign flush_done = (state_q == FLUSH) && (flush_q == 3'd4);
  assign kl         = k_q + l_q;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    flush_d   = flush_q;
    k_d       = k_q;
    l_d       = l_q;
    m_d       = m_q;
    cfg_err_d = cfg_err_q;
    case (state_q)
      FILL: if (acc) begin
        fill_d = fill_q + CW'(1);
        if (fill_d == kl) state_d = RUN;
      end
      FLUSH: begin
        flush_d = flush_q + 3'd1;
        if (flush_done) begin
          state_d = FILL;
          fill_d  = '0;
          flush_d = '0;
        end
      end
      default: ;
    endcase
    // cfg_load is only looked at while samples can be accepted
    if (cfg_load && in_ready) begin
      cfg_err_d = !cfg_ok;
      if (cfg_ok) begin
        k_d     = cfg_k;
        l_d     = cfg_l;
        m_d     = cfg_m;
        state_d = FLUSH;
        flush_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FILL;
      fill_q    <= '0;
      flush_q   <= '0;
      k_q       <= CW'(2);
      l_q       <= CW'(4);
      m_q       <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      flush_q   <= flush_d;
      k_q       <= k_d;
      l_q       <= l_d;
      m_q       <= m_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_comb begin
    x_d = x_q;
    if (acc) x_d = {x_q[DEPTH-1:0], in_data};
    if (flush_done) x_d = '0;

    // emit tag decided at acceptance so FILL samples never surface later
    vld_pipe_d  = {vld_pipe_q[STAGES-1:0], acc};
    emit_pipe_d = {emit_pipe_q[STAGES-1:0], acc && (state_q == RUN)};
    if (cfg_acc) emit_pipe_d = '0;

    d_d   = zext(x_q[0]) - zext(x_q[k_q]) - zext(x_q[l_q]) + zext(x_q[kl]);
    d2_d  = d_q;
    p_d   = vld_pipe_q[1] ? p_q + d_q : p_q;
    m_ext = {{(ACC_W-M_W){1'b0}}, m_q};
    r_d   = m_ext * d2_q + p_q;
    s_d   = vld_pipe_q[3] ? s_q + r_q : s_q;
    if (flush_done) begin
      p_d = '0;
      s_d = '0;
    end

    sh         = s_q >>> SHIFT;
    clamp      = (sh > OUT_MAX) || (sh < OUT_MIN);
    out_data_d = out_data_q;
    if (vld_pipe_q[STAGES]) begin
      if (sh > OUT_MAX)      out_data_d = OUT_MAX[OUT_W-1:0];
      else if (sh < OUT_MIN) out_data_d = OUT_MIN[OUT_W-1:0];
      else                   out_data_d = sh[OUT_W-1:0];
    end
    out_valid_d = vld_pipe_q[STAGES] && emit_pipe_q[STAGES] && !cfg_acc;
    sat_d       = cfg_acc ? 1'b0 : (sat_q || (out_valid_d && clamp));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      vld_pipe_q  <= '0;
      emit_pipe_q <= '0;
      d_q         <= '0;
      d2_q        <= '0;
      p_q         <= '0;
      r_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      x_q         <= x_d;
      vld_pipe_q  <= vld_pipe_d;
      emit_pipe_q <= emit_pipe_d;
      d_q         <= d_d;
      d2_q        <= d2_d;
      p_q         <= p_d;
      r_q         <= r_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_q       <= sat_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_trapezoid_shaper.sv
// Random + directed bench for trapezoid_shaper; two instances (SHIFT 0 and 4)
// share stimulus and are checked against a per-sample arithmetic model.
module tb_trapezoid_shaper;
  localparam int ADC_W = 16, OUT_W = 16, DEPTH = 32, M_W = 8, ACC_W = 32;
  localparam int CW   = $clog2(DEPTH+1);
  localparam int OMAX = (1 << (OUT_W-1)) - 1;
  localparam int OMIN = -(1 << (OUT_W-1));
  localparam int M_FILL = 0, M_RUN = 1, M_FLUSH = 2;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, cfg_load;
  logic [ADC_W-1:0] in_data;
  logic [CW-1:0] cfg_k, cfg_l;
  logic [M_W-1:0] cfg_m;
  logic in_ready0, in_ready4, cfg_err0, cfg_err4, out_valid0, out_valid4, sat0, sat4;
  logic signed [OUT_W-1:0] out_data0, out_data4;

  always #5 clk = ~clk;

  trapezoid_shaper #(.ADC_W(ADC_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .M_W(M_W),
                     .ACC_W(ACC_W), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_l(cfg_l),
    .cfg_m(cfg_m), .cfg_err(cfg_err0), .out_valid(out_valid0),
    .out_data(out_data0), .sat_flag(sat0));

  trapezoid_shaper #(.ADC_W(ADC_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .M_W(M_W),
                     .ACC_W(ACC_W), .SHIFT(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_l(cfg_l),
    .cfg_m(cfg_m), .cfg_err(cfg_err4), .out_valid(out_valid4),
    .out_data(out_data4), .sat_flag(sat4));

  typedef struct {int due; int s;} exp_t;
  exp_t expq[$];
  int   hist[$];
  int   cap[$];
  int   m_k, m_l, m_m, m_p, m_s, m_fill, m_flush, m_mode;
  bit   m_err, m_sat0, m_sat4, cap_en;
  int   cyc, n_chk, n_fail, nval, n_nrdy;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int clampv(int v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  function automatic int xh(int i);
    return (i < hist.size()) ? hist[i] : 0;
  endfunction

  task automatic model_reset();
    expq.delete(); hist.delete();
    m_k = 2; m_l = 4; m_m = 0; m_p = 0; m_s = 0;
    m_fill = 0; m_flush = 0; m_mode = M_FILL;
    m_err = 0; m_sat0 = 0; m_sat4 = 0;
  endtask

  task automatic check_outputs();
    bit ev;
    int s;
    ev = (expq.size() > 0) && (expq[0].due == cyc);
    if (out_valid0) nval++;
    if (!in_ready0) n_nrdy++;
    if (cap_en && out_valid0) cap.push_back(int'(out_data0));
    chk("in_ready0", in_ready0, m_mode != M_FLUSH);
    chk("in_ready4", in_ready4, m_mode != M_FLUSH);
    chk("out_valid0", out_valid0, ev);
    chk("out_valid4", out_valid4, ev);
    if (ev) begin
      s = expq[0].s;
      void'(expq.pop_front());
      chk("out_data0", out_data0, clampv(s));
      chk("out_data4", out_data4, clampv(s >>> 4));
      if (clampv(s) != s) m_sat0 = 1;
      if (clampv(s >>> 4) != (s >>> 4)) m_sat4 = 1;
    end
    chk("sat_flag0", sat0, m_sat0);
    chk("sat_flag4", sat4, m_sat4);
    chk("cfg_err0", cfg_err0, m_err);
    chk("cfg_err4", cfg_err4, m_err);
  endtask

  // One clock: drive at negedge, advance the model across the edge, check after it.
  task automatic step(input bit iv, input int dat, input bit cl, input int ck,
                      input int cl2, input int cm);
    int e, d, r;
    bit rdy, acc, ok, cacc;
    in_valid = iv; in_data = dat[ADC_W-1:0]; cfg_load = cl;
    cfg_k = ck[CW-1:0]; cfg_l = cl2[CW-1:0]; cfg_m = cm[M_W-1:0];
    e    = cyc + 1;
    rdy  = (m_mode != M_FLUSH);
    acc  = iv && rdy;
    ok   = (ck >= 1) && (ck <= cl2) && (ck + cl2 <= DEPTH);
    cacc = cl && rdy && ok;
    if (m_mode == M_FLUSH) begin
      if (m_flush == 4) begin
        m_mode = M_FILL; m_fill = 0; m_p = 0; m_s = 0; hist.delete();
      end else m_flush++;
    end else begin
      if (acc) begin
        hist.push_front(dat);
        if (hist.size() > DEPTH + 4) void'(hist.pop_back());
        d = xh(0) - xh(m_k) - xh(m_l) + xh(m_k + m_l);
        m_p += d;
        r = m_m * d + m_p;
        m_s += r;
        if (m_mode == M_RUN && !cacc) expq.push_back('{e + 5, m_s});
        if (m_mode == M_FILL) begin
          m_fill++;
          if (m_fill == m_k + m_l) m_mode = M_RUN;
        end
      end
      if (cl) begin
        m_err = !ok;
        if (ok) begin
          m_k = ck; m_l = cl2; m_m = cm; m_mode = M_FLUSH; m_flush = 0;
          m_sat0 = 0; m_sat4 = 0; expq.delete();
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; in_valid = 1'b0; cfg_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    model_reset();
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data0", out_data0, 0);
    chk("rst_out_data4", out_data4, 0);
    chk("rst_sat", sat0, 0);
    chk("rst_cfg_err", cfg_err0, 0);
    chk("rst_in_ready", in_ready0, 1);
    reset = 1'b0;
  endtask

  task automatic impulse_run(input bit bubbles);
    for (int i = 0; i < 18; i++) begin
      step(1, (i == 7) ? 100 : 0, 0, 0, 0, 0);
      if (bubbles) step(0, 0, 0, 0, 0, 0);
    end
    idle(6);
  endtask

  task automatic check_impulse(input string tag);
    int imp_exp[8];
    imp_exp = '{100, 200, 200, 200, 200, 100, 0, 0};
    chk({tag, "_count"}, cap.size(), 11);
    for (int i = 0; i < 8; i++)
      chk({tag, "_val"}, (i < cap.size()) ? cap[i] : -1, imp_exp[i]);
  endtask

  initial begin
    bit r_cl, r_iv;
    int r_k, r_l, r_m, r_d;
    reset = 1'b1; in_valid = 0; in_data = 0; cfg_load = 0;
    cfg_k = 0; cfg_l = 0; cfg_m = 0;
    cyc = 0; n_chk = 0; n_fail = 0; nval = 0; n_nrdy = 0; cap_en = 0;
    model_reset();
    do_reset(3);

    // warm-up with default k=2, l=4: only the 7th sample surfaces
    nval = 0;
    for (int i = 0; i < 7; i++) step(1, $urandom_range(0, 1000), 0, 0, 0, 0);
    idle(6);
    chk("warmup_outputs", nval, 1);

    // rejected then accepted configuration
    step(0, 0, 1, 3, 2, 0);
    chk("cfg_bad_err", cfg_err0, 1);
    step(0, 0, 1, 20, 20, 0);
    n_nrdy = 0;
    step(1, 5, 1, 3, 3, 0);
    for (int i = 0; i < 5; i++) step(1, 7, 0, 0, 0, 0);
    chk("flush_len", n_nrdy, 5);
    chk("cfg_ok_err", cfg_err0, 0);
    nval = 0;
    for (int i = 0; i < 6; i++) step(1, $urandom_range(0, 500), 0, 0, 0, 0);
    idle(6);
    chk("refill_no_out", nval, 0);

    // impulse, contiguous then with bubbles
    step(0, 0, 1, 2, 5, 0); idle(5);
    cap.delete(); cap_en = 1; impulse_run(0); cap_en = 0;
    check_impulse("impulse");
    step(0, 0, 1, 2, 5, 0); idle(5);
    cap.delete(); cap_en = 1; impulse_run(1); cap_en = 0;
    check_impulse("bubbles");

    // saturation and its stickiness
    step(0, 0, 1, 1, 1, 255); idle(5);
    cap.delete(); cap_en = 1;
    for (int i = 0; i < 10; i++) step(1, 65535, 0, 0, 0, 0);
    idle(6); cap_en = 0;
    chk("sat_set", sat0, 1);
    chk("sat_value", (cap.size() > 0) ? cap[cap.size()-1] : 0, 32767);
    step(0, 0, 1, 2, 1, 0);
    chk("sat_kept", sat0, 1);
    step(0, 0, 1, 2, 4, 0);
    chk("sat_cleared", sat0, 0);
    idle(5);

    // randomized traffic with occasional reconfiguration
    for (int i = 0; i < 3000; i++) begin
      r_cl = ($urandom_range(0, 59) == 0);
      r_iv = ($urandom_range(0, 3) != 0);
      r_k  = $urandom_range(0, 20);
      r_l  = $urandom_range(0, 20);
      r_m  = $urandom_range(0, 255);
      r_d  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 300);
      step(r_iv, r_d, r_cl, r_k, r_l, r_m);
    end
    idle(6);

    // reset two cycles after an in-flight impulse
    step(0, 0, 1, 2, 5, 0); idle(5);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 100, 0, 0, 0, 0);
    idle(2);
    do_reset(2);
    nval = 0;
    idle(8);
    chk("rst_no_out", nval, 0);
    chk("rst_ready", in_ready0, 1);
    for (int i = 0; i < 6; i++) step(1, $urandom_range(0, 1000), 0, 0, 0, 0);
    idle(6);
    chk("rst_refill_no_out", nval, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
